instr_mem_sync: RTL

Parametrised, synchronous-read instruction memory for the ARM pipeline; successor to the fixed 128-byte combinational ROM.
- Byte-addressed, big-endian word fetch, same byte ordering as today.
- Adds a boot-load write port with a LOAD/RUN mode FSM, a one-cycle registered fetch with a stall handshake, and fault reporting for misaligned or out-of-range fetches.
- Sits between the PC/fetch stage and the decode stage; the test harness or boot loader fills it before execution.

---
 rtl/instr_mem_sync.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_sync.sv
// Synchronous-read, byte-addressed, big-endian instruction memory with a boot-load
// write port, LOAD/RUN mode FSM, registered fetch with stall hold and fault reporting.
module instr_mem_sync #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_be,
    input  logic                  load_done,
    output logic                  wr_err,
    output logic [CNT_WIDTH-1:0]  load_count,
    output logic                  running,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    input  logic                  stall,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [1:0]            fault
);

    localparam int WORDS  = DEPTH_BYTES / 4;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Range checks are done one bit wider than the address so addr+3 never wraps.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH:0] LAST_OFS  = (ADDR_WIDTH+1)'(3);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_running;

    // Word-organised storage: bits [31:24] hold byte +0, matching the fetch order.
    logic [31:0]            r_mem [WORDS];

    logic [ADDR_WIDTH:0]    w_wr_end;
    logic                   w_wr_ok;
    logic [WIDX_W-1:0]      w_wr_idx;
    logic                   r_wr_err;
    logic [CNT_WIDTH-1:0]   r_load_count;

    logic [ADDR_WIDTH:0]    w_fe_end;
    logic [WIDX_W-1:0]      w_fe_idx;
    logic                   w_fetch_acc;
    logic [31:0]            w_rd_instr;
    logic [1:0]             w_rd_fault;
    logic                   r_instr_valid;
    logic [31:0]            r_instr;
    logic [1:0]             r_fault;

    // ---------------- mode FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_LOAD && load_done) begin
            w_next_state = ST_RUN;
        end
    end

    always_comb begin
        w_running = (r_state == ST_RUN);
    end

    // ---------------- boot-load write port ----------------
    assign w_wr_end = {1'b0, wr_addr} + LAST_OFS;
    assign w_wr_idx = wr_addr[WIDX_W+1:2];
    assign w_wr_ok  = (r_state == ST_LOAD) && wr_en &&
                      (wr_addr[1:0] == 2'b00) && (w_wr_end < DEPTH_EXT);

    // NOTE: the array has no reset on purpose; contents must survive reset, and
    // leaving it out lets synthesis map it onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_err     <= 1'b0;
            r_load_count <= '0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            if (w_wr_ok && (r_load_count != '1)) begin
                r_load_count <= r_load_count + CNT_WIDTH'(1);
            end
        end
    end

    // ---------------- fetch path ----------------
    assign w_fetch_acc = fetch_req && w_running && !stall;
    assign w_fe_end    = {1'b0, fetch_addr} + LAST_OFS;
    assign w_fe_idx    = fetch_addr[WIDX_W+1:2];

    // Misalignment outranks the range check; both force the word to zero.
    always_comb begin
        w_rd_fault = FAULT_OK;
        w_rd_instr = 32'h0;
        if (fetch_addr[1:0] != 2'b00) begin
            w_rd_fault = FAULT_ALIGN;
        end else if (w_fe_end >= DEPTH_EXT) begin
            w_rd_fault = FAULT_RANGE;
        end else begin
            w_rd_instr = r_mem[w_fe_idx];
        end
    end

    // Stall freezes the whole output register; otherwise valid tracks the accept
    // and instr/fault keep their last value between accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
            r_instr       <= 32'h0;
            r_fault       <= FAULT_OK;
        end else if (!stall) begin
            r_instr_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_instr <= w_rd_instr;
                r_fault <= w_rd_fault;
            end
        end
    end

    assign fetch_ready = w_running && !stall;
    assign running     = w_running;
    assign wr_err      = r_wr_err;
    assign load_count  = r_load_count;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign fault       = r_fault;

endmodule
